mips_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the next-generation replacement for the single-cycle MUL path in the pipeline's execute stage, and it adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support. The execute stage issues an operation with a start pulse. The decode stage uses busy to stall MFHI/MFLO and further mul/div issues until done.

---
 rtl/mips_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_muldiv.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use shift-add (one multiplier bit per cycle), DIV/DIVU use
//   restoring division (one quotient bit per cycle). Signed operations work on
//   magnitudes and apply a two's-complement fixup in a final FIX cycle.
//   MTHI/MTLO write HI/LO directly in a single cycle without going busy.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        issue request (ignored while busy)
//   op           0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6/7 no-op
//   a            rs operand: multiplicand / dividend / MTHI-MTLO source
//   b            rt operand: multiplier / divisor
//   busy         iterative operation in flight
//   done         one-cycle pulse, HI/LO just updated
//   hi, lo       architectural HI and LO registers
//   div_by_zero  valid with done: completed DIV/DIVU had b == 0
// -----------------------------------------------------------------------------
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          accept_mul, accept_div, write_hi, write_lo;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    a_neg, b_neg, is_signed, b_zero;

  // Iteration datapath
  logic [WIDTH-1:0]   mcand;   // multiplicand magnitude
  logic [2*WIDTH-1:0] acc;     // {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   dvsr;    // divisor magnitude
  logic [WIDTH:0]     rem;     // partial remainder
  logic [WIDTH-1:0]   quo;     // dividend bits shifting out, quotient bits in
  logic               neg_q, neg_r, is_div, dz;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   rem_sh, diff;
  logic               qbit;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + ONE_2W;
  endfunction

  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] x,
                                             input logic take_abs);
    logic [WIDTH-1:0] ux;
    ux = x;
    return (take_abs && (x < 0)) ? neg_w(ux) : ux;
  endfunction

  assign a_s       = a;
  assign b_s       = b;
  assign a_neg     = (a_s < 0);
  assign b_neg     = (b_s < 0);
  assign is_signed = op[0];
  assign b_zero    = (b == '0);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU, OP_MULT: begin
              accept_mul = 1'b1;
              state_nxt  = MUL;
            end
            OP_DIVU, OP_DIV: begin
              accept_div = 1'b1;
              state_nxt  = DIV;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right keeping the adder carry.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring step: trial-subtract the divisor from the shifted remainder;
  // a non-negative difference yields a 1 quotient bit and is kept.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign diff     = rem_sh - {2'b00, dvsr};
  assign qbit     = ~diff[WIDTH+1];
  assign rem_next = qbit ? diff[WIDTH:0] : rem_sh[WIDTH:0];
  assign quo_next = {quo[WIDTH-2:0], qbit};

  assign prod   = neg_q ? neg_2w(acc) : acc;
  assign res_hi = is_div ? (neg_r ? neg_w(rem[WIDTH-1:0]) : rem[WIDTH-1:0])
                         : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (neg_q ? neg_w(quo) : quo) : prod[WIDTH-1:0];

  // Operand latch and iteration registers
  always_ff @(posedge clk) begin
    if (accept_mul) begin
      mcand  <= mag_w(a_s, is_signed);
      acc    <= {{WIDTH{1'b0}}, mag_w(b_s, is_signed)};
      neg_q  <= is_signed & (a_neg ^ b_neg);
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
    end else if (accept_div) begin
      rem    <= '0;
      dvsr   <= mag_w(b_s, is_signed);
      is_div <= 1'b1;
      if (b_zero) begin
        // Zero divisor: run the raw dividend so the remainder comes back as
        // the original a and the quotient as all ones, with no sign fixup.
        quo   <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        dz    <= 1'b1;
      end else begin
        quo   <= mag_w(a_s, is_signed);
        neg_q <= is_signed & (a_neg ^ b_neg);
        neg_r <= is_signed & a_neg;
        dz    <= 1'b0;
      end
    end else if (state == MUL) begin
      acc <= mul_next;
    end else if (state == DIV) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  // Architectural outputs and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      if (accept_mul || accept_div)        cnt <= CNT_INIT;
      else if (state == MUL || state == DIV) cnt <= cnt - CNT_LAST;
      if (write_hi) begin
        hi          <= a;
        done        <= 1'b1;
        div_by_zero <= 1'b0;
      end
      if (write_lo) begin
        lo          <= a;
        done        <= 1'b1;
        div_by_zero <= 1'b0;
      end
      if (state == FIX) begin
        hi          <= res_hi;
        lo          <= res_lo;
        done        <= 1'b1;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv
//   Directed and randomised checks of mips_muldiv at WIDTH=32 and WIDTH=8.
// -----------------------------------------------------------------------------
module tb_mips_muldiv;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  op8    = 3'd0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  mips_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts edges until done appears and the busy cycles seen on the way.
  task automatic wait_done(input bit sel8, input string tag, input int lat);
    int edges = 0;
    int bc    = 0;
    while ((sel8 ? done8 : done) !== 1'b1 && edges < 100) begin
      if ((sel8 ? busy8 : busy) === 1'b1) bc++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " busy cycles"}, 64'(bc), 64'(lat));
  endtask

  function automatic logic [64:0] ref32(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] px, py;
    logic signed [31:0] sx, sy;
    logic [63:0]        p;
    sx = x; sy = y; px = sx; py = sy;
    case (o)
      3'd0: begin p = 64'(x) * 64'(y); return {1'b0, p}; end
      3'd1: begin p = px * py;         return {1'b0, p}; end
      3'd2: if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
            else        return {1'b0, x % y, x / y};
      3'd3: if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                        return {1'b1 ^ 1'b1, 32'h0, 32'h8000_0000};
            else        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
      default: return '0;
    endcase
  endfunction

  function automatic logic [16:0] ref8(input logic [2:0] o, input logic [7:0] x,
                                       input logic [7:0] y);
    logic signed [15:0] px, py;
    logic signed [7:0]  sx, sy;
    logic [15:0]        p;
    sx = x; sy = y; px = sx; py = sy;
    case (o)
      3'd0: begin p = 16'(x) * 16'(y); return {1'b0, p}; end
      3'd1: begin p = px * py;         return {1'b0, p}; end
      3'd2: if (y == 0) return {1'b1, x, 8'hFF};
            else        return {1'b0, x % y, x / y};
      3'd3: if (y == 0) return {1'b1, x, 8'hFF};
            else if (x == 8'h80 && y == 8'hFF) return {1'b0, 8'h00, 8'h80};
            else        return {1'b0, 8'(sx % sy), 8'(sx / sy)};
      default: return '0;
    endcase
  endfunction

  initial begin
    logic [31:0] rx, ry;
    logic [7:0]  rx8, ry8;
    logic [2:0]  ro;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hilo", {hi, lo}, 64'h0);
    check("reset dz", 64'(div_by_zero), 64'(0));
    check("reset w8 state", 64'({busy8, done8, dz8, hi8, lo8}), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // MULTU with latency, busy length and single-cycle done
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(1'b0, "multu", 33);
    check("multu hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    @(posedge clk); #1;
    check("multu done pulse", 64'(done), 64'(0));
    check("multu busy after", 64'(busy), 64'(0));

    // MULT
    issue(3'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(1'b0, "mult neg", 33);
    check("mult neg hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done(1'b0, "mult minmin", 33);
    check("mult minmin hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    // DIV / DIVU
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, "div -7/2", 33);
    check("div -7/2 hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd2, 32'h0000_0007, 32'h0000_0002);
    wait_done(1'b0, "divu 7/2", 33);
    check("divu 7/2 hilo", {hi, lo}, 64'h0000_0001_0000_0003);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, "div ovf", 33);
    check("div ovf hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("div ovf dz", 64'(div_by_zero), 64'(0));

    // Divide by zero, then a start issued in the done cycle
    issue(3'd2, 32'h0000_1234, 32'h0);
    wait_done(1'b0, "divu by 0", 33);
    check("divu by 0 hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    check("divu by 0 dz", 64'(div_by_zero), 64'(1));
    issue(3'd0, 32'h0000_0003, 32'h0000_0005);
    wait_done(1'b0, "b2b multu", 33);
    check("b2b multu hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    check("b2b multu dz", 64'(div_by_zero), 64'(0));

    // DIV by zero with a negative dividend: no sign fixup
    issue(3'd3, 32'hFFFF_FF00, 32'h0);
    wait_done(1'b0, "div by 0", 33);
    check("div by 0 hilo", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);
    check("div by 0 dz", 64'(div_by_zero), 64'(1));

    // start while busy is ignored
    issue(3'd0, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd7; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, "ignore start", 28);
    check("ignore start hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    check("ignore start dz", 64'(div_by_zero), 64'(0));

    // Reset in the middle of an operation
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (6) @(posedge clk);
    #1;
    check("hold hilo mid-op", {hi, lo}, 64'h0000_0001_0000_0000);
    check("busy mid-op", 64'(busy), 64'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midop reset busy", 64'(busy), 64'(0));
    check("midop reset done", 64'(done), 64'(0));
    check("midop reset hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("after reset no done", 64'(done), 64'(0));
    check("after reset idle", 64'(busy), 64'(0));

    // MTLO / MTHI / no-op
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    check("mtlo lo", 64'(lo), 64'h0000_0000_DEAD_BEEF);
    check("mtlo done", 64'(done), 64'(1));
    check("mtlo busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("mtlo done pulse", 64'(done), 64'(0));
    issue(3'd4, 32'hCAFE_F00D, 32'h0);
    check("mthi hilo", {hi, lo}, 64'hCAFE_F00D_DEAD_BEEF);
    check("mthi done", 64'(done), 64'(1));
    check("mthi dz", 64'(div_by_zero), 64'(0));
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("noop done", 64'(done), 64'(0));
    check("noop busy", 64'(busy), 64'(0));
    check("noop hilo", {hi, lo}, 64'hCAFE_F00D_DEAD_BEEF);

    // Randomised, WIDTH=32
    for (int i = 0; i < 10; i++) begin
      rx = $urandom;
      ry = $urandom;
      ro = 3'($urandom_range(0, 3));
      if (i % 4 == 3) ry = ry & 32'h0000_000F;
      if (i == 5)     ry = 32'h0;
      if (i == 6)     rx = 32'h8000_0000;
      issue(ro, rx, ry);
      wait_done(1'b0, $sformatf("r32 %0d", i), 33);
      check($sformatf("r32 %0d op%0d a=%h b=%h", i, ro, rx, ry),
            64'({div_by_zero, hi, lo}), 64'(ref32(ro, rx, ry)));
    end

    // WIDTH=8: boundaries then random
    issue8(3'd3, 8'h80, 8'hFF);
    wait_done(1'b1, "w8 div ovf", 9);
    check("w8 div ovf", 64'({dz8, hi8, lo8}), 64'({1'b0, 8'h00, 8'h80}));
    issue8(3'd2, 8'h5A, 8'h00);
    wait_done(1'b1, "w8 divu by 0", 9);
    check("w8 divu by 0", 64'({dz8, hi8, lo8}), 64'({1'b1, 8'h5A, 8'hFF}));
    issue8(3'd1, 8'h80, 8'h7F);
    wait_done(1'b1, "w8 mult", 9);
    check("w8 mult", 64'({dz8, hi8, lo8}), 64'({1'b0, 16'hC080}));
    for (int i = 0; i < 24; i++) begin
      rx8 = 8'($urandom);
      ry8 = 8'($urandom);
      ro  = 3'(i % 4);
      if (i == 13) ry8 = 8'h00;
      issue8(ro, rx8, ry8);
      wait_done(1'b1, $sformatf("r8 %0d", i), 9);
      check($sformatf("r8 %0d op%0d a=%h b=%h", i, ro, rx8, ry8),
            64'({dz8, hi8, lo8}), 64'(ref8(ro, rx8, ry8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
